grammer_array_reader: RTL and testbench
=======================================

Name: grammer_array_reader

Overview:
- Receive-side counterpart of the rotating-slot array writer.
- Accepts a stream of 32-bit words, stores each one in a 4-slot bank in rotating slot order, and tags each word with the count-phase it arrived in.
- Once all four slots are filled (one frame), drains them to a downstream consumer over a valid/ready handshake.
- Sits between the array writer's output and the display/check logic.

Parameters:
- DATA_W, 32, width of data words.
- SLOTS, 4, number of bank slots. Fixed power of two; slot index width is clog2(SLOTS) = 2.
- CNT_W, 8, width of the arrival counter used for phase tagging.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word present.
- in_data  input  DATA_W  upstream word.
- in_ready  output  1  block can accept a word this cycle.
- out_valid  output  1  drained word present.
- out_data  output  DATA_W  drained word.
- out_slot  output  2  slot index of out_data.
- out_phase  output  2  phase tag of out_data.
- out_ready  input  1  downstream accepts the word.
- sig_display  input  1  pause request for the drain side.
- frame_done  output  1  one-cycle pulse after the last slot of a frame drains.
- err_overflow  output  1  sticky flag: a word was offered while not accepting.

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state=FILL, wr_slot=0, rd_slot=0, cnt=0.
  - frame_done=0, err_overflow=0, out_valid=0.
  - Bank contents don't-care; out_data reads 0 until the first drain.
- States: FILL, DRAIN.
- FILL:
  - in_ready=1.
  - On in_valid: bank[wr_slot] <= in_data; tag[wr_slot] <= phase(cnt); wr_slot+1 mod 4; cnt+1 mod 256.
  - On the accept with wr_slot==3: next state DRAIN, rd_slot=0.
- phase(cnt), evaluated on the pre-increment value:
  - 0 if cnt==0.
  - 1 if cnt<128.
  - 2 if cnt<192.
  - 3 otherwise.
- DRAIN:
  - in_ready=0.
  - out_valid = !sig_display (combinational).
  - out_data=bank[rd_slot], out_slot=rd_slot, out_phase=tag[rd_slot].
  - Transfer when out_valid && out_ready: rd_slot+1.
  - On the transfer with rd_slot==3: frame_done=1 next cycle, state returns to FILL, wr_slot=0.
- Handshake rules:
  - out_data, out_slot and out_phase stay stable while out_valid=1 and out_ready=0.
  - Raising sig_display drops out_valid in the same cycle with no transfer; the word is held and reoffered when sig_display falls.
- Latency: first word of a frame is offered the cycle after the 4th accept, i.e. one cycle of bubble.
- Overflow: in_valid=1 in DRAIN sets err_overflow=1, sticky until reset. The word is dropped, cnt does not advance.
- Wrap-around: cnt 255 -> 0; the next word is tagged phase 0.
- Simultaneous events:
  - Reset wins over all traffic.
  - Reset mid-DRAIN discards the frame; no frame_done is produced.
  - sig_display in FILL has no effect.

Optional Feature:
- Macro: GRAMMER_READER_DECODE_EN.
- Defined:
  - out_data is inverse-scaled by tag: phase 1 -> bank<<1, phase 2 -> bank<<2, phases 0/3 pass through.
  - Result is truncated to DATA_W; low bits lost by the writer are not recovered.
- Undefined: out_data = raw bank contents. Tags are still produced.

Decomposition:
- Package grammer_pkg holds:
  - typedef phase_t (2-bit), with constants PH_INIT=0, PH_DIV=1, PH_SHR=2, PH_ZERO=3.
  - Phase thresholds THR_DIV=8'h80 and THR_SHR=8'hC0.
  - typedef state_t {FILL, DRAIN}.
- One sub-module: grammer_phase_tag, a combinational cnt -> phase_t function block. The writer side reuses it so both ends share one phase definition.

Test Plan:
- Reset, then 4 words 0x10, 0x20, 0x30, 0x40 with out_ready=1 -> drained in slot order 0..3 with the same data. Tags are 0,1,1,1. frame_done pulses once, then in_ready returns to 1.
- Drive 130 words continuously -> words 129 and 130 (cnt 128, 129) are tagged 2. err_overflow=1, because in_valid was held during each DRAIN.
- Drain with out_ready=0 for 5 cycles on slot 1 -> out_data/out_slot held stable, rd_slot unchanged. Release -> slots 1..3 drain.
- Assert sig_display during DRAIN at slot 2 -> out_valid=0 and no transfer. Deassert -> slot 2 reoffered unchanged.
- Assert reset after 2 drained words -> next cycle state FILL, in_ready=1, no frame_done. A new frame restarts at slot 0 with tag 0.
- With GRAMMER_READER_DECODE_EN: stored 0x0000_0011 tagged phase 2 -> out_data=0x0000_0044. Without the macro -> 0x0000_0011.

Source files
------------

// File: rtl/grammer_pkg.sv
// Shared types and constants for the grammer array reader/writer pair.
// Both ends take their phase definition and slot geometry from this package.
package grammer_pkg;

   localparam int SLOTS  = 4;
   localparam int SLOT_W = $clog2(SLOTS);
   localparam int CNT_W  = 8;

   typedef logic [1:0]       phase_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam phase_t PH_INIT = 2'd0;
   localparam phase_t PH_DIV  = 2'd1;
   localparam phase_t PH_SHR  = 2'd2;
   localparam phase_t PH_ZERO = 2'd3;

   localparam cnt_t THR_DIV = 8'h80;
   localparam cnt_t THR_SHR = 8'hC0;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

endpackage

// File: rtl/grammer_phase_tag.sv
// Combinational arrival-count to phase mapping, shared by writer and reader
// so both ends agree on which scaling a word received.
module grammer_phase_tag
   import grammer_pkg::*;
(
   input  cnt_t   cnt_i,
   output phase_t phase_o
);

   always_comb begin
      if (cnt_i == '0) begin
         phase_o = PH_INIT;
      end else if (cnt_i < THR_DIV) begin
         phase_o = PH_DIV;
      end else if (cnt_i < THR_SHR) begin
         phase_o = PH_SHR;
      end else begin
         phase_o = PH_ZERO;
      end
   end

endmodule

// File: rtl/grammer_array_reader.sv
// Collects words into a 4-slot rotating bank, tags each with its arrival phase,
// then drains a full frame over valid/ready. Optional GRAMMER_READER_DECODE_EN undoes writer scaling.
module grammer_array_reader
   import grammer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic [SLOT_W-1:0] out_slot,
   output phase_t            out_phase,
   input  logic              out_ready,
   input  logic              sig_display,
   output logic              frame_done,
   output logic              err_overflow
);

   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

   state_t            state_q, state_d;
   logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
   logic [SLOT_W-1:0] rd_slot_q, rd_slot_d;
   cnt_t              cnt_q, cnt_d;
   logic              frame_done_q, frame_done_d;
   logic              err_overflow_q, err_overflow_d;

   logic [DATA_W-1:0] bank_q [SLOTS];
   phase_t            tag_q  [SLOTS];

   phase_t            arrival_phase;
   logic              accept;
   logic              xfer;
   logic [DATA_W-1:0] rd_word;
   phase_t            rd_tag;

   grammer_phase_tag u_phase_tag (
      .cnt_i   (cnt_q),
      .phase_o (arrival_phase)
   );

   assign in_ready  = (state_q == FILL);
   assign out_valid = (state_q == DRAIN) && !sig_display;
   assign accept    = (state_q == FILL) && in_valid;
   assign xfer      = out_valid && out_ready;

   // NOTE: every signal assigned in always_comb gets a default first, otherwise
   // a missed branch holds its old value and synthesis infers a latch.
   always_comb begin
      state_d        = state_q;
      wr_slot_d      = wr_slot_q;
      rd_slot_d      = rd_slot_q;
      cnt_d          = cnt_q;
      frame_done_d   = 1'b0;
      err_overflow_d = err_overflow_q;

      unique case (state_q)
         FILL: begin
            if (accept) begin
               wr_slot_d = wr_slot_q + 1'b1;
               cnt_d     = cnt_q + 1'b1;
               if (wr_slot_q == LAST_SLOT) begin
                  state_d   = DRAIN;
                  rd_slot_d = '0;
               end
            end
         end
         DRAIN: begin
            // Words offered while draining are dropped and do not advance cnt.
            if (in_valid) begin
               err_overflow_d = 1'b1;
            end
            if (xfer) begin
               rd_slot_d = rd_slot_q + 1'b1;
               if (rd_slot_q == LAST_SLOT) begin
                  state_d      = FILL;
                  wr_slot_d    = '0;
                  frame_done_d = 1'b1;
               end
            end
         end
         default: state_d = FILL;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= FILL;
         wr_slot_q      <= '0;
         rd_slot_q      <= '0;
         cnt_q          <= '0;
         frame_done_q   <= 1'b0;
         err_overflow_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_slot_q      <= wr_slot_d;
         rd_slot_q      <= rd_slot_d;
         cnt_q          <= cnt_d;
         frame_done_q   <= frame_done_d;
         err_overflow_q <= err_overflow_d;
      end
   end

   // NOTE: the bank and tags are storage, not control; they carry no reset
   // because every slot is written before it can be read.
   always_ff @(posedge clk) begin
      if (accept) begin
         bank_q[wr_slot_q] <= in_data;
         tag_q[wr_slot_q]  <= arrival_phase;
      end
   end

   assign rd_word = bank_q[rd_slot_q];
   assign rd_tag  = tag_q[rd_slot_q];

   always_comb begin
      out_data = '0;
      if (state_q == DRAIN) begin
`ifdef GRAMMER_READER_DECODE_EN
         unique case (rd_tag)
            PH_DIV:  out_data = rd_word << 1;
            PH_SHR:  out_data = rd_word << 2;
            default: out_data = rd_word;
         endcase
`else
         out_data = rd_word;
`endif
      end
   end

   assign out_slot     = rd_slot_q;
   assign out_phase    = (state_q == DRAIN) ? rd_tag : PH_INIT;
   assign frame_done   = frame_done_q;
   assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_grammer_array_reader.sv
// Self-checking bench for grammer_array_reader: directed frames plus random
// traffic compared against a frame-level behavioural model.
module tb_grammer_array_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [1:0]  out_slot;
   logic [1:0]  out_phase;
   logic        out_ready;
   logic        sig_display;
   logic        frame_done;
   logic        err_overflow;

   int n_pass  = 0;
   int n_total = 0;

   // Behavioural model: the words of the current frame, how many are stored,
   // how many have been drained, and the running arrival count.
   logic [31:0] m_data [4];
   logic [1:0]  m_tag  [4];
   int          m_n;
   int          m_rd;
   int          m_cnt;
   bit          m_ovf;
   bit          m_done;
   bit          m_drained_once;
   int          accepts;

   always #5 clk = ~clk;

   grammer_array_reader dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_slot     (out_slot),
      .out_phase    (out_phase),
      .out_ready    (out_ready),
      .sig_display  (sig_display),
      .frame_done   (frame_done),
      .err_overflow (err_overflow)
   );

   function automatic logic [1:0] ref_phase(input int c);
      if (c == 0)   return 2'd0;
      if (c < 128)  return 2'd1;
      if (c < 192)  return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic [31:0] ref_out(input logic [31:0] w, input logic [1:0] p);
`ifdef GRAMMER_READER_DECODE_EN
      if (p == 2'd1) return w * 2;
      if (p == 2'd2) return w * 4;
`endif
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_n = 0; m_rd = 0; m_cnt = 0;
      m_ovf = 1'b0; m_done = 1'b0; m_drained_once = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, check outputs, clock, update model.
   task automatic step(input logic v, input logic [31:0] d, input logic ordy,
                       input logic disp, input logic rst);
      bit draining, exp_valid;
      reset = rst; in_valid = v; in_data = d; out_ready = ordy; sig_display = disp;
      #1;
      draining  = (m_n == 4);
      exp_valid = draining && !disp;
      check("in_ready",     {31'd0, in_ready},     {31'd0, !draining});
      check("out_valid",    {31'd0, out_valid},    {31'd0, exp_valid});
      check("frame_done",   {31'd0, frame_done},   {31'd0, m_done});
      check("err_overflow", {31'd0, err_overflow}, {31'd0, m_ovf});
      if (exp_valid) begin
         check("out_data",  out_data,            ref_out(m_data[m_rd], m_tag[m_rd]));
         check("out_slot",  {30'd0, out_slot},   m_rd);
         check("out_phase", {30'd0, out_phase},  {30'd0, m_tag[m_rd]});
      end else if (!draining && !m_drained_once) begin
         check("out_data_idle", out_data, 32'd0);
      end
      @(posedge clk);
      m_done = 1'b0;
      if (rst) begin
         model_reset();
      end else if (draining) begin
         if (v) m_ovf = 1'b1;
         if (exp_valid && ordy) begin
            m_drained_once = 1'b1;
            m_rd++;
            if (m_rd == 4) begin
               m_n = 0; m_rd = 0; m_done = 1'b1;
            end
         end
      end else if (v) begin
         m_data[m_n] = d;
         m_tag[m_n]  = ref_phase(m_cnt);
         m_n++;
         m_cnt = (m_cnt + 1) % 256;
         accepts++;
      end
      @(negedge clk);
   endtask

   task automatic fill_frame();
      for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; sig_display = 1'b0;
      accepts = 0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_in_ready",     {31'd0, in_ready},     32'd1);
      check("rst_out_valid",    {31'd0, out_valid},    32'd0);
      check("rst_frame_done",   {31'd0, frame_done},   32'd0);
      check("rst_err_overflow", {31'd0, err_overflow}, 32'd0);
      check("rst_out_data",     out_data,              32'd0);
      @(negedge clk);

      // First frame: fixed words, sig_display in FILL must be ignored.
      step(1'b1, 32'h10, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h20, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h30, 1'b1, 1'b1, 1'b0);
      step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
      check("frame1_tag0", {30'd0, m_tag[0]}, 32'd0);
      check("frame1_tag3", {30'd0, m_tag[3]}, 32'd1);
      repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Continuous upstream traffic across phase thresholds and the cnt wrap.
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      accepts = 0;
      for (int i = 0; i < 2000 && accepts < 262; i++)
         step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
      check("accept_budget", {31'd0, (accepts >= 262)}, 32'd1);
      check("overflow_sticky", {31'd0, err_overflow}, 32'd1);
      repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Back-pressure on slot 1 for five cycles.
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      fill_frame();
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Display pause on slot 2.
      fill_frame();
      repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Reset mid-drain discards the frame; next frame restarts at slot 0, tag 0.
      fill_frame();
      repeat (2) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
      fill_frame();
      check("post_rst_tag0", {30'd0, m_tag[0]}, 32'd0);
      repeat (5) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);

      // Fully random traffic with random back-pressure and pauses.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
